// File: rtl/f1_start_controller.sv
// Start sequencer for the F1 start-lights FSM: paces the light build-up, inserts a
// pseudo-random all-lights-on hold, then times the driver's reaction or flags a jump start.
module f1_start_controller #(
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned DELAY_MIN       = 4,
  parameter int unsigned DELAY_RAND_BITS = 4,
  parameter int unsigned MS_DIV          = 100,
  parameter int unsigned TIME_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              react,
  input  logic              cmd_seq,
  input  logic              cmd_delay,
  output logic              lights_trigger,
  output logic              lights_en,
  output logic [TIME_W-1:0] reaction_time,
  output logic              time_valid,
  output logic              jump_start,
  output logic              busy
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUB_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned DLY_W  = $clog2(DELAY_MIN + (1 << DELAY_RAND_BITS) + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(MS_DIV - 1);
  localparam logic [TIME_W-1:0] TIME_MAX  = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEQ    = 3'd1;
  localparam logic [2:0] S_DELAY  = 3'd2;
  localparam logic [2:0] S_TIMING = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]        r_state;
  logic [6:0]        r_lfsr;
  logic              r_react_q;
  logic [TICK_W-1:0] r_tick;
  logic [DLY_W-1:0]  r_dly;
  logic [SUB_W-1:0]  r_sub;
  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] r_reaction_time;
  logic              r_time_valid;
  logic              r_jump_start;

  logic              w_react_rise;
  logic              w_tick_wrap;
  logic              w_accept;
  logic              w_seq_step;
  logic              w_delay_done;
  logic [DLY_W-1:0]  w_hold;
  logic              w_unused;

  assign w_unused     = cmd_seq;
  assign w_react_rise = react & ~r_react_q;
  assign w_tick_wrap  = (r_tick == TICK_LAST);
  assign w_accept     = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_FAULT);
  assign w_hold       = DLY_W'(DELAY_MIN) + DLY_W'(r_lfsr[DELAY_RAND_BITS-1:0]);

  // Build-up steps stop once the lights FSM reports all-on, so the SEQ->DELAY
  // cycle never carries a step.
  assign w_seq_step   = (r_state == S_SEQ) & w_tick_wrap & ~cmd_delay;
  assign w_delay_done = (r_state == S_DELAY) & w_tick_wrap & (r_dly <= DLY_W'(1));

  assign lights_trigger = rst_n & w_accept & start;
  assign lights_en      = ~w_react_rise & (w_seq_step | w_delay_done);
  assign busy           = (r_state == S_SEQ) | (r_state == S_DELAY) | (r_state == S_TIMING);
  assign reaction_time  = r_reaction_time;
  assign time_valid     = r_time_valid;
  assign jump_start     = r_jump_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= 7'h01;
      r_react_q <= 1'b0;
    end else begin
      r_lfsr    <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
      r_react_q <= react;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_tick          <= '0;
      r_dly           <= '0;
      r_sub           <= '0;
      r_time          <= '0;
      r_reaction_time <= '0;
      r_time_valid    <= 1'b0;
      r_jump_start    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            r_state      <= S_SEQ;
            r_tick       <= '0;
            r_time_valid <= 1'b0;
            r_jump_start <= 1'b0;
          end
        end

        S_SEQ: begin
          if (w_react_rise) begin
            r_state      <= S_FAULT;
            r_jump_start <= 1'b1;
            r_time_valid <= 1'b0;
          end else if (cmd_delay) begin
            r_state <= S_DELAY;
            r_tick  <= '0;
            r_dly   <= w_hold;
          end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
          end
        end

        S_DELAY: begin
          // A press coinciding with the lights-out step still counts as a jump start.
          if (w_react_rise) begin
            r_state      <= S_FAULT;
            r_jump_start <= 1'b1;
            r_time_valid <= 1'b0;
          end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap) begin
              if (r_dly <= DLY_W'(1)) begin
                r_state <= S_TIMING;
                r_time  <= '0;
                r_sub   <= '0;
              end else begin
                r_dly <= r_dly - 1'b1;
              end
            end
          end
        end

        S_TIMING: begin
          if (w_react_rise) begin
            r_state         <= S_DONE;
            r_reaction_time <= r_time;
            r_time_valid    <= 1'b1;
          end else if (r_sub == SUB_LAST) begin
            r_sub <= '0;
            if (r_time != TIME_MAX) begin
              r_time <= r_time + 1'b1;
            end
          end else begin
            r_sub <= r_sub + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_start_controller.sv
// Self-checking bench for f1_start_controller with a behavioural lights FSM and
// event-timeline reference derived from the tick, hold and reaction rules.
module tb_f1_start_controller;

  localparam int TD   = 4;
  localparam int MD   = 2;
  localparam int DMIN = 2;
  localparam int DRB  = 2;
  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          react = 1'b0;
  logic          cmd_seq;
  logic          cmd_delay;
  logic          lights_trigger;
  logic          lights_en;
  logic [TW-1:0] reaction_time;
  logic          time_valid;
  logic          jump_start;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int exp_rt = 0;

  f1_start_controller #(
    .TICK_DIV(TD),
    .DELAY_MIN(DMIN),
    .DELAY_RAND_BITS(DRB),
    .MS_DIV(MD),
    .TIME_W(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .react(react),
    .cmd_seq(cmd_seq),
    .cmd_delay(cmd_delay),
    .lights_trigger(lights_trigger),
    .lights_en(lights_en),
    .reaction_time(reaction_time),
    .time_valid(time_valid),
    .jump_start(jump_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Lights FSM: trigger -> S1, each step advances, S8 (all on) steps back to S0.
  int ls;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ls <= 0;
    else if (lights_trigger) ls <= 1;
    else if (lights_en)      ls <= (ls == 8) ? 0 : ls + 1;
  end
  assign cmd_seq   = (ls >= 1) && (ls <= 7);
  assign cmd_delay = (ls == 8);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 7'h01;
    else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  logic [6:0] lfsr_hist [4096];
  int         en_q[$];
  int         trig_q[$];
  bit         overlap = 1'b0;
  always @(negedge clk) begin
    lfsr_hist[cyc[11:0]] <= m_lfsr;
    if (lights_en) en_q.push_back(cyc);
    if (lights_trigger) trig_q.push_back(cyc);
    if (lights_trigger && lights_en) overlap <= 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_en(input int n, output bit ok);
    int b = 0;
    while (en_q.size() < n && b < 300) begin
      step();
      b++;
    end
    ok = (en_q.size() >= n);
  endtask

  task automatic launch(output int t, output int base, output int tb0);
    base  = en_q.size();
    tb0   = trig_q.size();
    start = 1'b1;
    t     = cyc;
    step();
    start = 1'b0;
  endtask

  function automatic int hold_at(input int d);
    logic [11:0] idx;
    idx = d[11:0];
    return DMIN + int'(lfsr_hist[idx][DRB-1:0]);
  endfunction

  function automatic int expect_rt(input int k);
    int v;
    v = (k - 1) / MD;
    return (v > TMAX) ? TMAX : v;
  endfunction

  task automatic press_at(input int c);
    if (cyc > c) begin
      errors++;
      $display("FAIL press_schedule now %0d past target %0d", cyc, c);
    end
    step_to(c);
    react = 1'b1;
    step();
    react = 1'b0;
  endtask

  // Full start sequence up to lights out; returns the lights-out cycle.
  task automatic run_to_lights_out(output int e);
    int t, base, tb0, d;
    bit ok;
    launch(t, base, tb0);
    checks++;
    if (busy !== 1'b1 || jump_start !== 1'b0 || time_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_entry busy/jump/valid got %b%b%b need 100", busy, jump_start, time_valid);
    end
    wait_en(base + 8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lights_out_timeout got %0d steps need 8", en_q.size() - base);
      e = cyc;
      return;
    end
    checks++;
    if (trig_q.size() != tb0 + 1 || trig_q[tb0] != t) begin
      errors++;
      $display("FAIL trigger_cycle got %0d pulses (first %0d) need 1 at %0d",
               trig_q.size() - tb0, (trig_q.size() > tb0) ? trig_q[tb0] : -1, t);
    end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (en_q[base+k-1] != t + TD * k) begin
        errors++;
        $display("FAIL step%0d_cycle got %0d need %0d", k, en_q[base+k-1] - t, TD * k);
      end
    end
    d = t + 7 * TD + 1;
    e = d + TD * hold_at(d);
    checks++;
    if (en_q[base+7] != e) begin
      errors++;
      $display("FAIL lights_out_cycle got %0d need %0d", en_q[base+7] - t, e - t);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timing_busy got %b need 1", busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({lights_trigger, lights_en, time_valid, jump_start, busy} !== 5'b0 || reaction_time !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b rt %0d need 00000 rt 0",
               {lights_trigger, lights_en, time_valid, jump_start, busy}, reaction_time);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if ({lights_trigger, lights_en, time_valid, jump_start, busy} !== 5'b0 || reaction_time !== '0) begin
      errors++;
      $display("FAIL idle_outputs got %b rt %0d need 00000 rt 0",
               {lights_trigger, lights_en, time_valid, jump_start, busy}, reaction_time);
    end
  endtask

  task automatic test_reaction();
    int e, k;
    for (int i = 0; i < 6; i++) begin
      k = (i == 0) ? 11 : (i == 1) ? 1 : int'($urandom_range(2, 50));
      run_to_lights_out(e);
      press_at(e + k);
      exp_rt = expect_rt(k);
      checks++;
      if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1 || jump_start !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reaction k=%0d got rt %0d v%b j%b b%b need rt %0d v1 j0 b0",
                 k, reaction_time, time_valid, jump_start, busy, exp_rt);
      end
      repeat (5) step();
    end
    repeat (15) step();
    checks++;
    if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got rt %0d v%b b%b need rt %0d v1 b0", reaction_time, time_valid, busy, exp_rt);
    end
  endtask

  task automatic test_saturation();
    int e, k;
    k = int'($urandom_range(41, 70));
    run_to_lights_out(e);
    press_at(e + k);
    exp_rt = TMAX;
    checks++;
    if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1) begin
      errors++;
      $display("FAIL saturation k=%0d got rt %0d v%b need rt %0d v1", k, reaction_time, time_valid, exp_rt);
    end
    repeat (3) step();
  endtask

  task automatic check_fault(input string name, input int base, input int n_en);
    repeat (50) step();
    checks++;
    if (jump_start !== 1'b1 || time_valid !== 1'b0 || busy !== 1'b0 || reaction_time !== TW'(exp_rt)) begin
      errors++;
      $display("FAIL %s_flags got j%b v%b b%b rt %0d need j1 v0 b0 rt %0d",
               name, jump_start, time_valid, busy, reaction_time, exp_rt);
    end
    checks++;
    if (en_q.size() - base != n_en) begin
      errors++;
      $display("FAIL %s_steps got %0d need %0d", name, en_q.size() - base, n_en);
    end
  endtask

  task automatic test_jump_start();
    int t, base, tb0, r, n, d, e;
    bit ok;
    launch(t, base, tb0);
    wait_en(base + 3, ok);
    if (ok) press_at(en_q[base+2] + 2);
    check_fault("jump_seq", base, 3);
    for (int i = 0; i < 5; i++) begin
      launch(t, base, tb0);
      r = t + int'($urandom_range(1, 7 * TD + 1 + TD * DMIN));
      press_at(r);
      n = 0;
      for (int k = 1; k <= 7; k++) if (t + TD * k < r) n++;
      check_fault("jump_rand", base, n);
    end
    launch(t, base, tb0);
    step_to(t + 7 * TD + 2);
    d = t + 7 * TD + 1;
    press_at(d + TD * hold_at(d));
    check_fault("jump_at_lights_out", base, 7);
    run_to_lights_out(e);
    press_at(e + 3);
    exp_rt = expect_rt(3);
    checks++;
    if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1 || jump_start !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_fault got rt %0d v%b j%b need rt %0d v1 j0",
               reaction_time, time_valid, jump_start, exp_rt);
    end
  endtask

  task automatic test_start_busy_held_react();
    int t, base, tb0, d, e, b;
    react = 1'b1;
    step();
    launch(t, base, tb0);
    b = 0;
    while (en_q.size() < base + 8 && b < 300) begin
      start = (b % 3 == 1);
      step();
      b++;
    end
    start = 1'b0;
    checks++;
    if (trig_q.size() != tb0 + 1) begin
      errors++;
      $display("FAIL busy_start_trigger got %0d pulses need 1", trig_q.size() - tb0);
    end
    d = t + 7 * TD + 1;
    e = d + TD * hold_at(d);
    checks++;
    if (en_q.size() < base + 8 || en_q[base+7] != e) begin
      errors++;
      $display("FAIL busy_start_lights_out got %0d steps need 8 with last at %0d", en_q.size() - base, e - t);
    end
    repeat (10) step();
    checks++;
    if (busy !== 1'b1 || time_valid !== 1'b0 || jump_start !== 1'b0) begin
      errors++;
      $display("FAIL held_react got b%b v%b j%b need b1 v0 j0", busy, time_valid, jump_start);
    end
    react = 1'b0;
    press_at(e + 20);
    exp_rt = expect_rt(20);
    checks++;
    if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1) begin
      errors++;
      $display("FAIL repress got rt %0d v%b need rt %0d v1", reaction_time, time_valid, exp_rt);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_delay();
    int t, base, tb0, e;
    launch(t, base, tb0);
    step_to(t + 7 * TD + 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lights_trigger, lights_en, time_valid, jump_start, busy} !== 5'b0 || reaction_time !== '0) begin
      errors++;
      $display("FAIL async_reset got %b rt %0d need 00000 rt 0",
               {lights_trigger, lights_en, time_valid, jump_start, busy}, reaction_time);
    end
    exp_rt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();
    run_to_lights_out(e);
    press_at(e + 6);
    exp_rt = expect_rt(6);
    checks++;
    if (reaction_time !== TW'(exp_rt) || time_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_reaction got rt %0d v%b need rt %0d v1", reaction_time, time_valid, exp_rt);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL trigger_en_overlap got %b need 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_reaction();
    test_saturation();
    test_jump_start();
    test_start_busy_held_react();
    test_reset_mid_delay();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f1_start_controller.md
Name: f1_start_controller

Overview:
- Sequencer for the F1 start-lights FSM: drives its `trigger` and `en` inputs and watches its `cmd_seq` and `cmd_delay` outputs.
- Paces the light build-up at a fixed tick rate and inserts a pseudo-random hold with all lights on.
- Releases the lights and measures driver reaction time in prescaled units.
- Flags a jump start if the driver reacts before the lights go out. Sits between the top level (buttons, display) and the lights FSM.

Parameters:
- TICK_DIV, 1000: clock cycles per light step; also the unit of the random hold.
- DELAY_MIN, 4: minimum hold, in ticks.
- DELAY_RAND_BITS, 4: number of LFSR bits added to the hold, giving a range of 0..2^DELAY_RAND_BITS-1 extra ticks.
- MS_DIV, 100: clock cycles per reaction-time unit.
- TIME_W, 16: width of the reaction time.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new start sequence; level, acted on in an accepting state.
- react  in  1  driver button; rising edge is used.
- cmd_seq  in  1  from lights FSM: lights building up.
- cmd_delay  in  1  from lights FSM: all lights on.
- lights_trigger  out  1  one-cycle pulse to the lights FSM `trigger`.
- lights_en  out  1  one-cycle step pulse to the lights FSM `en`.
- reaction_time  out  TIME_W  last measured reaction, in MS_DIV units.
- time_valid  out  1  reaction_time holds a fresh result.
- jump_start  out  1  last attempt was a jump start.
- busy  out  1  high in SEQ, DELAY and TIMING.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all outputs 0.
  - LFSR = 7'h01; all counters 0; react edge register 0.
- LFSR: 7-bit Fibonacci, x^7+x^6+1, advances every cycle in every state; never reaches 0. Hold = DELAY_MIN + lfsr[DELAY_RAND_BITS-1:0], sampled on entry to DELAY.
- react_rise = react & ~react_q, where react_q is react registered every cycle.
- IDLE / DONE / FAULT (accepting states):
  - start=1: pulse lights_trigger for one cycle, clear tick_cnt, clear time_valid and jump_start, go to SEQ.
  - start=0: outputs hold their values.
- SEQ:
  - tick_cnt counts 0..TICK_DIV-1 and wraps; lights_en=1 in the cycle tick_cnt==TICK_DIV-1.
  - First lights_en occurs TICK_DIV cycles after the trigger cycle.
  - cmd_delay sampled 1: clear tick_cnt, load delay_cnt with the hold, go to DELAY. This happens the cycle after the 7th lights_en (lights FSM S7→S8).
  - lights_en is never asserted in the same cycle as the SEQ→DELAY transition.
- DELAY:
  - lights_en held 0; tick_cnt keeps counting; delay_cnt decrements at each tick wrap.
  - Wrap with delay_cnt==1: assert lights_en for one cycle (lights FSM S8→S0, lights out), clear time_cnt and sub_cnt, go to TIMING.
- TIMING:
  - sub_cnt counts 0..MS_DIV-1; time_cnt increments on each sub_cnt wrap.
  - time_cnt saturates at 2^TIME_W-1 and does not wrap.
  - react_rise: reaction_time ← time_cnt, time_valid ← 1, go to DONE.
- Jump start: react_rise in SEQ or DELAY sets jump_start=1, time_valid=0, reaction_time unchanged, go to FAULT. No further lights_en is issued; the lights FSM is left where it is.
- react_rise and the DELAY-ending lights_en in the same cycle: treated as a jump start (FAULT).
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values.
- busy = state ∈ {SEQ, DELAY, TIMING}.
- lights_trigger and lights_en are never both 1 in the same cycle.

Test Plan:
- Nominal sequence (TICK_DIV=4, MS_DIV=2, DELAY_MIN=2, DELAY_RAND_BITS=2): start pulse at cycle T → lights_trigger at T; lights_en at T+4, T+8, …, T+28 (7 pulses); DELAY entered at T+29; final lights_en between 8 and 20 cycles after DELAY entry; busy=1 throughout.
- Reaction measurement: same config, react rises 11 cycles after the final lights_en → reaction_time=5, time_valid=1, jump_start=0, busy=0.
- Jump start: react rises 2 cycles after the 3rd lights_en → jump_start=1, no further lights_en, state FAULT, reaction_time unchanged; a following start restarts cleanly with jump_start cleared.
- Saturation (TIME_W=4, MS_DIV=1): no react for 40 cycles after lights out, then react → reaction_time=15.
- Start while busy and held react: start pulses during SEQ are ignored (no extra lights_trigger); react held high from before start gives no rise in TIMING until released and re-pressed.
- Async reset mid-DELAY: rst_n low mid-cycle → all outputs 0 immediately; after release, start gives a normal sequence with the LFSR restarted from 7'h01.
